// File: rtl/mem_resp_pkg.sv
// Shared types, widths and the request-legality check for the mem_resp_mc responder.
package mem_resp_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Request latched on entry to the miss path; the word index is held separately.
    typedef struct packed {
        logic              wr;
        logic [WORD_W-1:0] din;
    } req_t;

    // A request is rejected when Rd and Wr collide, the address is odd, or the word is out of range.
    function automatic logic req_err(input logic              rd,
                                     input logic              wr,
                                     input logic [WORD_W-1:0] addr,
                                     input int unsigned       mem_words);
        return (rd | wr) &
               ((rd & wr) | addr[0] | (32'(addr[WORD_W-1:1]) >= mem_words));
    endfunction

endpackage

// File: rtl/mem_resp_hitbuf.sv
// One-entry read hit buffer (valid/tag/data). Built only when MEM_RESP_HIT_BUF_EN is defined.
module mem_resp_hitbuf
    import mem_resp_pkg::*;
#(
    parameter int unsigned IDX_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  lookup_idx_i,
    input  logic              upd_en_i,
    input  logic [IDX_W-1:0]  upd_idx_i,
    input  logic [WORD_W-1:0] upd_data_i,
    output logic              hit_o,
    output logic [WORD_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  tag_q, tag_d;
    logic [WORD_W-1:0] data_q, data_d;

    // Every miss completion allocates; a write to the buffered word just refreshes its data.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (upd_en_i) begin
            valid_d = 1'b1;
            tag_d   = upd_idx_i;
            data_d  = upd_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_idx_i);
    assign data_o = data_q;

endmodule

// File: rtl/mem_resp_mc.sv
// Multi-cycle data-memory responder: fixed-latency misses, same-cycle error/hit completions.
// Optional one-entry hit buffer enabled by defining MEM_RESP_HIT_BUF_EN.
module mem_resp_mc
    import mem_resp_pkg::*;
#(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [IDX_W-1:0]  req_idx_q, req_idx_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic [WORD_W-1:0] mem_q [MEM_WORDS];

    logic              req_c, err_c, hit_c, commit_c;
    logic [IDX_W-1:0]  idx_c;
    logic [WORD_W-1:0] rdata_c, hb_data_c;
    logic              unused_createdump;

    assign unused_createdump = createdump;

    assign req_c    = Rd | Wr;
    assign err_c    = req_err(Rd, Wr, Addr, MEM_WORDS);
    assign idx_c    = IDX_W'(Addr[WORD_W-1:1]);
    assign rdata_c  = mem_q[req_idx_q];
    assign commit_c = (state_q == BUSY) && (cnt_q == CNT_W'(1));

`ifdef MEM_RESP_HIT_BUF_EN
    logic              hb_match_c;
    logic [WORD_W-1:0] hb_upd_data_c;

    assign hb_upd_data_c = req_q.wr ? req_q.din : rdata_c;

    mem_resp_hitbuf #(
        .IDX_W(IDX_W)
    ) u_hitbuf (
        .clk          (clk),
        .rst_n        (rst),
        .lookup_idx_i (idx_c),
        .upd_en_i     (commit_c),
        .upd_idx_i    (req_idx_q),
        .upd_data_i   (hb_upd_data_c),
        .hit_o        (hb_match_c),
        .data_o       (hb_data_c)
    );

    assign hit_c = Rd & ~Wr & ~err_c & hb_match_c;
`else
    assign hit_c     = 1'b0;
    assign hb_data_c = '0;
`endif

    // Next state: latch the request in IDLE, count down in BUSY, commit on the BUSY->DONE edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        req_idx_d = req_idx_q;
        dout_d    = dout_q;
        case (state_q)
            IDLE: begin
                if (req_c && !err_c && !hit_c) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_W'(LATENCY - 1);
                    req_d.wr  = Wr;
                    req_d.din = DataIn;
                    req_idx_d = idx_c;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (!req_q.wr) begin
                        dout_d = rdata_c;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            req_idx_q <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            req_idx_q <= req_idx_d;
            dout_q    <= dout_d;
        end
    end

    // Storage is deliberately not reset; commits only happen from BUSY, which reset leaves.
    always_ff @(posedge clk) begin
        if (commit_c && req_q.wr) begin
            mem_q[req_idx_q] <= req_q.din;
        end
    end

    // Responses; held low during reset so an abandoned miss drops Stall at once.
    always_comb begin
        DataOut  = '0;
        Done     = 1'b0;
        Stall    = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (err_c) begin
                        Done = 1'b1;
                        err  = 1'b1;
                    end else if (hit_c) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = hb_data_c;
                    end else if (req_c) begin
                        Stall = 1'b1;
                    end
                end
                BUSY: Stall = 1'b1;
                DONE: begin
                    Done    = 1'b1;
                    DataOut = dout_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_resp_mc.sv
// Self-checking bench for mem_resp_mc: LATENCY=4 and LATENCY=2 instances, table plus corner sequences.
module tb_mem_resp_mc;

    localparam int unsigned LAT0 = 4;
    localparam int unsigned LAT1 = 2;
`ifdef MEM_RESP_HIT_BUF_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr [2];
    logic [15:0] din  [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [15:0] dout [2];
    logic        done [2];
    logic        stall[2];
    logic        hit  [2];
    logic        errs [2];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        err;
        logic        hit;
        bit          cmp_data;
        logic [15:0] data;
        int          lat;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        e_err;
        logic        e_hit_hb;
        bit          e_cmp;
        logic [15:0] e_data;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];

    always #5 clk = ~clk;

    mem_resp_mc #(.LATENCY(LAT0), .MEM_WORDS(1024)) u_dut0 (
        .clk(clk), .rst(rst), .Addr(addr[0]), .DataIn(din[0]), .Rd(rd[0]), .Wr(wr[0]),
        .createdump(1'b0), .DataOut(dout[0]), .Done(done[0]), .Stall(stall[0]),
        .CacheHit(hit[0]), .err(errs[0])
    );

    mem_resp_mc #(.LATENCY(LAT1), .MEM_WORDS(1024)) u_dut1 (
        .clk(clk), .rst(rst), .Addr(addr[1]), .DataIn(din[1]), .Rd(rd[1]), .Wr(wr[1]),
        .createdump(1'b0), .DataOut(dout[1]), .Done(done[1]), .Stall(stall[1]),
        .CacheHit(hit[1]), .err(errs[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_ne(input string nm, input logic [31:0] act, input logic [31:0] bad);
        n_cmp++;
        if (act === bad) begin
            n_err++;
            $display("FAIL %s: got %0h which must not be returned", nm, act);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic [15:0] a, input logic [15:0] di,
                       input logic e_err, input logic e_hit_hb, input bit e_cmp, input logic [15:0] e_data);
        vec_t v;
        v = '{r, w, a, di, e_err, e_hit_hb, e_cmp, e_data};
        vt.push_back(v);
    endtask

    // Issue one request (called at posedge+1), hold it until Done, then drop it and check quiet IDLE.
    task automatic do_req(input int d, input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] di, input logic e_err, input logic e_hit,
                          input bit e_cmp, input logic [15:0] e_data, output logic [15:0] got);
        exp_t  e;
        exp_t  p;
        int    lat;
        int    cyc;
        bit    seen;
        string tg;
        tg  = $sformatf("d%0d %s%s@%04h", d, r ? "R" : "", w ? "W" : "", a);
        lat = (e_err || e_hit) ? 0 : ((d == 0) ? int'(LAT0) : int'(LAT1));
        e   = '{e_err, e_hit, e_cmp, e_data, lat};
        sb.push_back(e);
        rd[d] = r; wr[d] = w; addr[d] = a; din[d] = di;
        cyc = 0; seen = 1'b0; got = '0;
        while (!seen && cyc <= lat + 4) begin
            @(negedge clk);
            if (done[d]) begin
                seen = 1'b1;
            end else begin
                chk($sformatf("%s stall c%0d", tg, cyc), 32'(stall[d]), 32'd1);
                cyc++;
                @(posedge clk); #1;
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: no Done after %0d cycles, required at %0d", tg, cyc, lat);
            p = sb.pop_front();
        end else begin
            p = sb.pop_front();
            chk({tg, " latency"},    32'(cyc),      32'(p.lat));
            chk({tg, " err"},        32'(errs[d]),  32'(p.err));
            chk({tg, " hit"},        32'(hit[d]),   32'(p.hit));
            chk({tg, " stall@done"}, 32'(stall[d]), 32'd0);
            if (p.cmp_data) chk({tg, " data"}, 32'(dout[d]), 32'(p.data));
            got = dout[d];
        end
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(negedge clk);
        chk({tg, " no 2nd done"}, 32'(done[d]),  32'd0);
        chk({tg, " idle stall"},  32'(stall[d]), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; din[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset Done", d),     32'(done[d]),  32'd0);
            chk($sformatf("d%0d reset Stall", d),    32'(stall[d]), 32'd0);
            chk($sformatf("d%0d reset CacheHit", d), 32'(hit[d]),   32'd0);
            chk($sformatf("d%0d reset err", d),      32'(errs[d]),  32'd0);
            chk($sformatf("d%0d reset DataOut", d),  32'(dout[d]),  32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // rd wr addr din | err hit(buffer on) cmp data
        add(0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 16'h0000);
        add(1, 0, 16'h0010, 16'h0000, 0, 1, 1, 16'hBEEF);
        add(1, 0, 16'h0010, 16'h0000, 0, 1, 1, 16'hBEEF);
        add(1, 0, 16'h0011, 16'h0000, 1, 0, 0, 16'h0000);
        add(0, 1, 16'h0020, 16'h1111, 0, 0, 0, 16'h0000);
        add(1, 1, 16'h0020, 16'h2222, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0800, 16'h0000, 1, 0, 0, 16'h0000);
        add(0, 1, 16'h0011, 16'hDEAD, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0010, 16'h0000, 0, 0, 1, 16'hBEEF);
        add(1, 0, 16'h0020, 16'h0000, 0, 0, 1, 16'h1111);
        add(0, 1, 16'h07FE, 16'hCAFE, 0, 0, 0, 16'h0000);
        add(0, 1, 16'hFFFE, 16'h0BAD, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h07FE, 16'h0000, 0, 1, 1, 16'hCAFE);
        add(0, 1, 16'h0010, 16'h1357, 0, 0, 0, 16'h0000);
        add(1, 0, 16'h0010, 16'h0000, 0, 1, 1, 16'h1357);
        add(1, 0, 16'h0020, 16'h0000, 0, 0, 1, 16'h1111);
        add(0, 1, 16'h0020, 16'h2468, 0, 0, 0, 16'h0000);
        add(1, 0, 16'h0020, 16'h0000, 0, 1, 1, 16'h2468);

        foreach (vt[i]) begin
            do_req(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].din, vt[i].e_err,
                   HB && vt[i].e_hit_hb, vt[i].e_cmp, vt[i].e_data, got);
        end

        // Reset in cycle 2 of a pending write: outputs drop at once and the write is lost.
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'h0040; din[0] = 16'h1234;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid-busy Stall", 32'(stall[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst Done",     32'(done[0]),  32'd0);
        chk("rst Stall",    32'(stall[0]), 32'd0);
        chk("rst CacheHit", 32'(hit[0]),   32'd0);
        chk("rst err",      32'(errs[0]),  32'd0);
        chk("rst DataOut",  32'(dout[0]),  32'd0);
        @(posedge clk); #1;
        wr[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(0, 1, 0, 16'h0020, 16'h0000, 0, 0, 1, 16'h2468, got);
        do_req(0, 1, 0, 16'h0040, 16'h0000, 0, 0, 0, 16'h0000, got);
        chk_ne("aborted write data", 32'(got), 32'h1234);

        // LATENCY=2 instance: read, write, read back.
        do_req(1, 1, 0, 16'h0002, 16'h0000, 0, 0, 0, 16'h0000, got);
        do_req(1, 0, 1, 16'h0002, 16'h5A5A, 0, 0, 0, 16'h0000, got);
        do_req(1, 1, 0, 16'h0002, 16'h0000, 0, HB, 1, 16'h5A5A, got);
        do_req(1, 1, 0, 16'h0003, 16'h0000, 1, 0, 0, 16'h0000, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
